vline_move_sched: RTL and testbench
===================================

Name: vline_move_sched

Overview:
- Sequencer for a bank of N vertical-line mover counters (3/5/5/3-bit cascaded up/down loadable counters; bounds flagged by UTC = 487, DTC = 18).
- Loads all movers from switches, then on each frame tick issues single-cycle UP/DW step pulses, round-robin per line.
- Bounces each line at its bound and arbitrates a shared load request against stepping.
- Sits between the VGA frame-tick source and the mover instances.

Parameters:
- N_LINES, 4, number of mover counters driven (>=1).
- STEPS, 2, steps applied to every line per frame tick (1..15).
- DIR_INIT, 0, initial direction for all lines after load (0 = up, 1 = down).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- frame_tick  in  1  one-cycle pulse per video frame
- load_req  in  1  one-cycle pulse: reload all movers from switches
- run  in  1  level; 1 = stepping enabled, 0 = paused
- enable  in  N_LINES  per-line step enable
- utc  in  N_LINES  mover at upper bound (487)
- dtc  in  N_LINES  mover at lower bound (18)
- up  out  N_LINES  step-up pulse to mover i
- dw  out  N_LINES  step-down pulse to mover i
- ld  out  N_LINES  load strobe to mover i
- dir  out  N_LINES  current direction per line (0 up, 1 down)
- busy  out  1  high in LOAD, STEP, SETTLE
- overrun  out  1  sticky: frame_tick arrived while busy stepping

Behaviour:
- All outputs registered.
- Reset (reset = 0, asynchronous):
  - state = IDLE; up = dw = ld = 0; dir = {N{DIR_INIT}}; busy = 0; overrun = 0; idx = 0; step_cnt = 0.
- States: IDLE, LOAD, WAIT, STEP, SETTLE.
- IDLE:
  - No pulses.
  - load_req -> LOAD.
  - frame_tick is ignored until the first load.
- LOAD (1 cycle):
  - ld = all ones for exactly one cycle; dir <= {N{DIR_INIT}}; overrun <= 0; -> WAIT.
- WAIT:
  - load_req -> LOAD. load_req has priority over frame_tick in the same cycle.
  - Else frame_tick & run -> STEP with idx = 0, step_cnt = 0.
  - frame_tick with run = 0 is dropped; no overrun is flagged.
- STEP (1 cycle, line idx):
  - If enable[idx] = 0: no pulse.
  - Else if dir[idx] = 0:
    - utc[idx] = 0 -> up[idx] = 1.
    - utc[idx] = 1 -> dir[idx] <= 1; dw[idx] = 1 unless dtc[idx] = 1.
  - Else if dir[idx] = 1:
    - dtc[idx] = 0 -> dw[idx] = 1.
    - dtc[idx] = 1 -> dir[idx] <= 0; up[idx] = 1 unless utc[idx] = 1.
  - utc & dtc both high on a line: no pulse, direction unchanged.
  - At most one of up/dw/ld is high on any line in any cycle.
  - -> SETTLE.
- SETTLE (1 cycle):
  - No pulses. Lets the mover's utc/dtc update before that line is examined again.
  - If idx < N_LINES-1: idx++, -> STEP.
  - Else if step_cnt < STEPS-1: idx = 0, step_cnt++, -> STEP.
  - Else -> WAIT.
- Frame cost: exactly 2·N_LINES·STEPS cycles from the cycle after frame_tick is sampled. Disabled lines still consume their slot, so timing is deterministic.
- frame_tick during STEP/SETTLE:
  - Ignored for stepping; sets overrun (sticky until LOAD or reset).
- load_req during STEP/SETTLE:
  - Aborts the sequence; the current cycle's pulses are suppressed; LOAD follows next cycle.
- run deasserted mid-sequence: the current frame completes; only new frames are blocked.
- Reset mid-operation: all pulses drop to 0 immediately (asynchronous).

Test Plan:
- Reset, then load_req -> ld = 4'b1111 for exactly 1 cycle, dir = 0000, busy high 1 cycle, then WAIT with no pulses.
- run = 1, enable = 1111, all utc/dtc = 0, one frame_tick -> up[0],up[1],up[2],up[3],up[0],…,up[3] at cycles 1,3,5,…,15 after the tick; no dw; 16 busy cycles.
- Line 2 utc = 1, dir[2] = 0, frame_tick -> dir[2] flips to 1; dw[2] pulses in its slots instead of up[2]; other lines still step up.
- Line 1 utc = dtc = 1 -> no pulse on line 1 for the whole frame; dir[1] unchanged. enable[3] = 0 -> no pulse on line 3, frame still 16 cycles.
- frame_tick again 4 cycles after the first -> overrun = 1 and sequence unchanged; then load_req -> overrun = 0 and ld pulses.
- load_req issued in cycle 6 of a frame -> pulses stop that cycle; ld = 1111 next cycle; assert reset during STEP -> up/dw/ld = 0 at once, state IDLE.

Source files
------------

// File: rtl/vline_move_sched_if.sv
// Bundle between the frame-tick/load control side and the bank of vertical-line movers.
interface vline_move_sched_if #(
  parameter int unsigned N_LINES = 4
);
  logic               frame_tick;
  logic               load_req;
  logic               run;
  logic [N_LINES-1:0] enable;
  logic [N_LINES-1:0] utc;
  logic [N_LINES-1:0] dtc;
  logic [N_LINES-1:0] up;
  logic [N_LINES-1:0] dw;
  logic [N_LINES-1:0] ld;
  logic [N_LINES-1:0] dir;
  logic               busy;
  logic               overrun;

  modport master (
    output frame_tick, load_req, run, enable, utc, dtc,
    input  up, dw, ld, dir, busy, overrun
  );

  modport slave (
    input  frame_tick, load_req, run, enable, utc, dtc,
    output up, dw, ld, dir, busy, overrun
  );
endinterface

// File: rtl/vline_move_sched.sv
// Round-robin step sequencer for a bank of bouncing vertical-line mover counters.
// Pulses are decided on the edge that enters STEP, so they appear in the STEP cycle itself.
module vline_move_sched #(
  parameter int unsigned N_LINES  = 4,
  parameter int unsigned STEPS    = 2,
  parameter bit          DIR_INIT = 1'b0
) (
  input logic               clk,
  input logic               reset,
  vline_move_sched_if.slave bus
);

  localparam int unsigned IW = (N_LINES > 1) ? $clog2(N_LINES) : 1;
  localparam int unsigned CW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_LINES - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    STEP,
    SETTLE
  } state_t;

  state_t             state, state_n;
  logic [IW-1:0]      idx, idx_n;
  logic [CW-1:0]      step_cnt, step_cnt_n;
  logic [N_LINES-1:0] up_q, up_n;
  logic [N_LINES-1:0] dw_q, dw_n;
  logic [N_LINES-1:0] ld_q, ld_n;
  logic [N_LINES-1:0] dir_q, dir_n;
  logic               busy_q, busy_n;
  logic               overrun_q, overrun_n;
  logic               dir_cur;
  logic               at_end;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      step_cnt  <= '0;
      up_q      <= '0;
      dw_q      <= '0;
      ld_q      <= '0;
      dir_q     <= {N_LINES{DIR_INIT}};
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      step_cnt  <= step_cnt_n;
      up_q      <= up_n;
      dw_q      <= dw_n;
      ld_q      <= ld_n;
      dir_q     <= dir_n;
      busy_q    <= busy_n;
      overrun_q <= overrun_n;
    end
  end

  // Next state and the outputs that go with it
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    step_cnt_n = step_cnt;
    up_n       = '0;
    dw_n       = '0;
    ld_n       = '0;
    dir_n      = dir_q;
    overrun_n  = overrun_q;
    dir_cur    = 1'b0;
    at_end     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.load_req) state_n = LOAD;
      end
      LOAD: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (bus.load_req) begin
          state_n = LOAD;
        end else if (bus.frame_tick && bus.run) begin
          state_n    = STEP;
          idx_n      = '0;
          step_cnt_n = '0;
        end
      end
      STEP: begin
        if (bus.frame_tick) overrun_n = 1'b1;
        state_n = bus.load_req ? LOAD : SETTLE;
      end
      SETTLE: begin
        if (bus.frame_tick) overrun_n = 1'b1;
        if (bus.load_req) begin
          state_n = LOAD;
        end else if (idx < LAST_IDX) begin
          idx_n   = idx + IW'(1);
          state_n = STEP;
        end else if (step_cnt < LAST_CNT) begin
          idx_n      = '0;
          step_cnt_n = step_cnt + CW'(1);
          state_n    = STEP;
        end else begin
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n == LOAD) begin
      ld_n      = '1;
      dir_n     = {N_LINES{DIR_INIT}};
      overrun_n = 1'b0;
    end

    // Bounce: reverse at the bound ahead, then step; a line pinned at both bounds stays put
    if (state_n == STEP && bus.enable[idx_n] && !(bus.utc[idx_n] && bus.dtc[idx_n])) begin
      dir_cur = dir_q[idx_n];
      at_end  = dir_cur ? bus.dtc[idx_n] : bus.utc[idx_n];
      if (at_end) dir_cur = ~dir_cur;
      dir_n[idx_n] = dir_cur;
      if (dir_cur) dw_n[idx_n] = 1'b1;
      else         up_n[idx_n] = 1'b1;
    end

    busy_n = (state_n == LOAD) || (state_n == STEP) || (state_n == SETTLE);
  end

  assign bus.up      = up_q;
  assign bus.dw      = dw_q;
  assign bus.ld      = ld_q;
  assign bus.dir     = dir_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_vline_move_sched.sv
// Scoreboard bench: a frame-position reference model predicts every output cycle,
// a monitor compares on the falling edge, and simple mover counters close the utc/dtc loop.
module tb_vline_move_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned S  = 2;
  localparam bit          DI = 1'b0;
  localparam int          F  = 2 * N * S;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vline_move_sched_if #(.N_LINES(N)) bus ();

  vline_move_sched #(
    .N_LINES (N),
    .STEPS   (S),
    .DIR_INIT(DI)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] up;
    logic [N-1:0] dw;
    logic [N-1:0] ld;
    logic [N-1:0] dir;
    logic         busy;
    logic         ovr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  int           pos[N];
  int           sw[N];
  logic [N-1:0] force_both;

  // Reference model state: frame position 0 = not stepping, 1..F = cycle within frame
  bit           loaded;
  bit           in_load;
  int           fpos;
  logic [N-1:0] mdir;
  bit           movr;

  // Mover counters: load from switches, count on up/dw pulses
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset)          pos[i] <= 100;
      else if (bus.ld[i])  pos[i] <= sw[i];
      else if (bus.up[i])  pos[i] <= pos[i] + 1;
      else if (bus.dw[i])  pos[i] <= pos[i] - 1;
    end
  end

  always_comb begin
    bus.utc = '0;
    bus.dtc = '0;
    for (int i = 0; i < N; i++) begin
      bus.utc[i] = (pos[i] == 487) || force_both[i];
      bus.dtc[i] = (pos[i] == 18)  || force_both[i];
    end
  end

  // Reference model: one expected output set per cycle
  initial begin : model
    exp_t e;
    bit   go_load;
    int   line;
    logic d;
    logic at_end;
    loaded  = 0;
    in_load = 0;
    fpos    = 0;
    mdir    = {N{DI}};
    movr    = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        loaded  = 0;
        in_load = 0;
        fpos    = 0;
        mdir    = {N{DI}};
        movr    = 0;
        e       = '0;
        e.dir   = {N{DI}};
        if (q.size() > 0) void'(q.pop_back());
        q.push_back(e);
      end else begin
        go_load = 0;
        e       = '0;
        if (!loaded) begin
          go_load = bus.load_req;
        end else if (in_load) begin
          fpos = 0;
        end else if (fpos == 0) begin
          if (bus.load_req) go_load = 1;
          else if (bus.frame_tick && bus.run) fpos = 1;
        end else begin
          if (bus.frame_tick) movr = 1;
          if (bus.load_req) go_load = 1;
          else begin
            fpos++;
            if (fpos > F) fpos = 0;
          end
        end
        in_load = go_load;
        if (go_load) begin
          loaded = 1;
          fpos   = 0;
          mdir   = {N{DI}};
          movr   = 0;
          e.ld   = '1;
        end
        if (fpos % 2 == 1) begin
          line = ((fpos - 1) / 2) % N;
          if (bus.enable[line] && !(bus.utc[line] && bus.dtc[line])) begin
            d      = mdir[line];
            at_end = d ? bus.dtc[line] : bus.utc[line];
            if (at_end) d = ~d;
            mdir[line] = d;
            if (d) e.dw[line] = 1'b1;
            else   e.up[line] = 1'b1;
          end
        end
        e.dir  = mdir;
        e.ovr  = movr;
        e.busy = in_load || (fpos != 0);
        q.push_back(e);
      end
    end
  end

  // Monitor: pop the prediction for this cycle and compare mid-cycle
  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {bus.up, bus.dw, bus.ld, bus.dir, bus.busy, bus.overrun};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t up=%b/%b dw=%b/%b ld=%b/%b dir=%b/%b busy=%b/%b ovr=%b/%b (got/exp)",
                   $time, a.up, e.up, a.dw, e.dw, a.ld, e.ld, a.dir, e.dir,
                   a.busy, e.busy, a.ovr, e.ovr);
        end
      end
    end
  end

  task automatic check_reset();
    total++;
    if (bus.up !== '0 || bus.dw !== '0 || bus.ld !== '0 || bus.dir !== {N{DI}} ||
        bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset state t=%0t up=%b dw=%b ld=%b dir=%b busy=%b ovr=%b",
               $time, bus.up, bus.dw, bus.ld, bus.dir, bus.busy, bus.overrun);
    end
  endtask

  task automatic wait_not_busy(input int max_cycles);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL wait for idle expired after %0d cycles t=%0t", max_cycles, $time);
    end
  endtask

  task automatic pulse_ft();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_ld();
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    bus.frame_tick = 1'b0;
    bus.load_req   = 1'b0;
    bus.run        = 1'b0;
    bus.enable     = '1;
    force_both     = '0;
    for (int i = 0; i < N; i++) sw[i] = 100;

    reset = 1'b0;
    idle(3);
    check_reset();
    reset = 1'b1;
    idle(2);

    // Tick before any load is ignored
    bus.run = 1'b1;
    pulse_ft();
    idle(2);

    pulse_ld();
    idle(3);

    // Plain frame, all lines step up
    pulse_ft();
    idle(18);
    wait_not_busy(F + 4);

    // Line 2 loaded at the upper bound bounces downward
    sw[2] = 487;
    pulse_ld();
    idle(2);
    pulse_ft();
    idle(18);

    // Line 1 pinned at both bounds, line 3 disabled
    force_both[1] = 1'b1;
    bus.enable[3] = 1'b0;
    pulse_ft();
    idle(18);
    force_both = '0;
    bus.enable = '1;

    // Second tick four cycles into a frame sets overrun; load clears it
    pulse_ft();
    idle(3);
    pulse_ft();
    idle(16);
    pulse_ld();
    idle(3);

    // Tick dropped while paused
    bus.run = 1'b0;
    pulse_ft();
    idle(3);
    bus.run = 1'b1;

    // Load request in cycle 6 of a frame aborts it
    pulse_ft();
    idle(5);
    pulse_ld();
    idle(3);
    wait_not_busy(4);

    // Asynchronous reset while a step pulse is out
    pulse_ft();
    idle(1);
    @(posedge clk);
    #2 reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    pulse_ld();
    idle(2);

    // Randomized phase with movers parked near their bounds
    for (int c = 0; c < 700; c++) begin
      bus.frame_tick = ($urandom_range(0, 9) == 0);
      bus.run        = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.enable = N'($urandom);
      if ($urandom_range(0, 29) == 0)
        force_both = ($urandom_range(0, 2) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      bus.load_req = 1'b0;
      if ($urandom_range(0, 39) == 0 && (fpos % 2 == 0) && !in_load) begin
        for (int i = 0; i < N; i++)
          sw[i] = ($urandom_range(0, 1) == 0) ? 18 + int'($urandom_range(0, 4))
                                              : 487 - int'($urandom_range(0, 4));
        bus.load_req = 1'b1;
      end
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    bus.load_req   = 1'b0;
    idle(20);

    if (bad == 0) $display("PASS test done: total=%0d bad=%0d", total, bad);
    else          $display("FAIL test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
